pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width, legal range 28..64.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0180, PC value on trap or misaligned jump-register.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries, legal range 2..16.
REQ-005 SHALL have port: clk  in  1  clock, rising edge.
REQ-006 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: stall  in  1  hold PC and RAS.
REQ-008 SHALL have port: trap  in  1  redirect to TRAP_VEC.
REQ-009 SHALL have port: pcsrc  in  1  branch taken.
REQ-010 SHALL have port: jump  in  1  absolute jump.
REQ-011 SHALL have port: link  in  1  push return address (jal/jalr).
REQ-012 SHALL have port: jr  in  1  register jump.
REQ-013 SHALL have port: ret  in  1  return, qualifies jr.
REQ-014 SHALL have port: signimm  in  ADDR_W  sign-extended branch offset, in words.
REQ-015 SHALL have port: instr_index  in  26  jump index field.
REQ-016 SHALL have port: jr_target  in  ADDR_W  register target.
REQ-017 SHALL have port: pc  out  ADDR_W  current PC.
REQ-018 SHALL have port: pc_plus4  out  ADDR_W  pc+4, combinational.
REQ-019 SHALL have port: ras_empty  out  1  no valid RAS entries.
REQ-020 SHALL have port: ras_full  out  1  RAS_DEPTH valid entries.
REQ-021 SHALL have port: misalign_err  out  1  one-cycle pulse on misaligned jr target.

Function
REQ-022 SHALL compute all address arithmetic modulo 2^ADDR_W; pc_plus4 wraps from all-ones-minus-3 to 0.
REQ-023 SHALL compute next-PC with priority: trap > stall > jr > jump > pcsrc > sequential.
REQ-024 SHALL load TRAP_VEC on trap regardless of stall; RAS unchanged.
REQ-025 SHALL hold pc and all RAS state when stall=1 and trap=0; inputs other than trap are ignored.
REQ-026 SHALL form jr target as RAS top when ret=1 and RAS non-empty, else jr_target.
REQ-027 SHALL, when the selected jr target has bits[1:0]!=0, load TRAP_VEC and pulse misalign_err for exactly the following cycle.
REQ-028 SHALL form jump target as {pc_plus4[ADDR_W-1:28], instr_index, 2'b00}.
REQ-029 SHALL form branch target as pc_plus4 + (signimm<<2), truncated to ADDR_W.
REQ-030 SHALL let jump win when jump and pcsrc are both 1 (no reserved-zero case).
REQ-031 SHALL pop the RAS on an accepted jr with ret=1 and non-empty stack; pop on empty is a no-op.
REQ-032 SHALL push pc_plus4 on an accepted jump or jr with link=1.
REQ-033 SHALL, on push when full, overwrite the oldest entry (circular) and keep count at RAS_DEPTH.
REQ-034 SHALL, on simultaneous pop and push, replace the top entry; count unchanged.
REQ-035 SHALL ignore link and ret when neither jump nor jr is accepted.
REQ-036 SHALL assert ras_empty when count==0 and ras_full when count==RAS_DEPTH, both registered-state derived.

Reset
REQ-037 SHALL, on rst_n low, asynchronously set pc=RESET_VEC, RAS count=0, misalign_err=0; RAS storage need not clear.
REQ-038 SHALL, on reset mid-operation, discard any pending redirect or pulse; first post-reset edge yields RESET_VEC+4 when no controls are asserted.

Verification
REQ-039 SHALL cover: reset release, all controls 0, 3 cycles -> pc 0,4,8,12.
REQ-040 SHALL cover: pc=0x100, pcsrc=1, signimm=-2 -> pc=0xFC; jump and pcsrc both 1, instr_index=0x40 -> pc=0x100.
REQ-041 SHALL cover: pc=0x200, jump+link -> RAS top 0x204; later jr+ret with jr_target=0x999C -> pc=0x204, ras_empty=1.
REQ-042 SHALL cover: RAS_DEPTH+1 pushes of 0x10,0x20,... -> ras_full=1; RAS_DEPTH pops return newest-first, oldest entry lost.
REQ-043 SHALL cover: jr, jr_target=0x1002 -> pc=TRAP_VEC, misalign_err high one cycle; stall=1 with trap=1 -> pc=TRAP_VEC.
REQ-044 SHALL cover: pc=0xFFFF_FFFC, no controls -> pc=0; stall held 5 cycles -> pc and RAS unchanged.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (trap/stall/jr/jump/branch/sequential)
// with a circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0180),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              trap,
    input  logic              pcsrc,
    input  logic              jump,
    input  logic              link,
    input  logic              jr,
    input  logic              ret,
    input  logic [ADDR_W-1:0] signimm,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              misalign_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(28'hFFF_FFFF);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [CNT_W-1:0]  count;

    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] jr_sel;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] pc_next;
    logic              use_ras;
    logic              jr_mis;
    logic              mis_next;
    logic              do_push;
    logic              do_pop;

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_DEPTH);

    always_comb begin
        pc_plus4   = pc + ADDR_W'(4);
        top_inc    = (top == PTR_LAST) ? '0 : top + PTR_W'(1);
        top_dec    = (top == '0) ? PTR_LAST : top - PTR_W'(1);
        ras_top    = ras_mem[top];
        use_ras    = ret && !ras_empty;
        jr_sel     = use_ras ? ras_top : jr_target;
        jr_mis     = (jr_sel[1:0] != 2'b00);
        branch_tgt = pc_plus4 + (signimm << 2);
        // Region bits come from pc+4, low 28 bits from the index field.
        jump_tgt   = (pc_plus4 & ~LOW_MASK) | ADDR_W'({instr_index, 2'b00});

        pc_next  = pc_plus4;
        mis_next = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;

        if (trap) begin
            pc_next = TRAP_VEC;
        end else if (stall) begin
            pc_next = pc;
        end else if (jr) begin
            // A misaligned register jump traps and leaves the RAS untouched.
            if (jr_mis) begin
                pc_next  = TRAP_VEC;
                mis_next = 1'b1;
            end else begin
                pc_next = jr_sel;
                do_pop  = use_ras;
                do_push = link;
            end
        end else if (jump) begin
            pc_next = jump_tgt;
            do_push = link;
        end else if (pcsrc) begin
            pc_next = branch_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_VEC;
            misalign_err <= 1'b0;
            top          <= '0;
            count        <= '0;
        end else begin
            pc           <= pc_next;
            misalign_err <= mis_next;
            if (do_push && !do_pop) begin
                top   <= top_inc;
                count <= ras_full ? count : count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                top   <= top_dec;
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; only count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && do_pop) begin
            ras_mem[top] <= pc_plus4;
        end else if (do_push) begin
            ras_mem[top_inc] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, trap, pcsrc, jump, link, jr, ret;
    logic [31:0] signimm;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus4;
    logic        ras_empty, ras_full, misalign_err;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1000000;
    localparam logic [6:0] C_TRAP  = 7'b0100000;
    localparam logic [6:0] C_PCSRC = 7'b0010000;
    localparam logic [6:0] C_JUMP  = 7'b0001000;
    localparam logic [6:0] C_LINK  = 7'b0000100;
    localparam logic [6:0] C_JR    = 7'b0000010;
    localparam logic [6:0] C_RET   = 7'b0000001;

    pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .trap        (trap),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .link        (link),
        .jr          (jr),
        .ret         (ret),
        .signimm     (signimm),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".pc"},       pc,                  e.pc);
            chk({e.name, ".pc_plus4"}, pc_plus4,            e.pc + 32'd4);
            chk({e.name, ".empty"},    32'(ras_empty),      32'(e.empty));
            chk({e.name, ".full"},     32'(ras_full),       32'(e.full));
            chk({e.name, ".mis"},      32'(misalign_err),   32'(e.mis));
        end
    end

    task automatic step(input string name, input logic rstn, input logic [6:0] ctl,
                        input logic [31:0] simm, input logic [25:0] idx, input logic [31:0] jrt,
                        input logic [31:0] epc, input logic ee, input logic ef, input logic em);
        exp_t e;
        @(negedge clk);
        rst_n = rstn;
        {stall, trap, pcsrc, jump, link, jr, ret} = ctl;
        signimm     = simm;
        instr_index = idx;
        jr_target   = jrt;
        e.name = name; e.pc = epc; e.empty = ee; e.full = ef; e.mis = em;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        {stall, trap, pcsrc, jump, link, jr, ret} = C_NONE;
        signimm = '0; instr_index = '0; jr_target = '0;

        step("rst0", 0, C_NONE, 0, 0, 0, 32'h0, 1, 0, 0);
        step("rst1", 0, C_NONE, 0, 0, 0, 32'h0, 1, 0, 0);
        step("seq4",  1, C_NONE, 0, 0, 0, 32'h4, 1, 0, 0);
        step("seq8",  1, C_NONE, 0, 0, 0, 32'h8, 1, 0, 0);
        step("seq12", 1, C_NONE, 0, 0, 0, 32'hC, 1, 0, 0);

        step("jmp100",   1, C_JUMP,           0,            26'h40, 0, 32'h100, 1, 0, 0);
        step("br_neg",   1, C_PCSRC,          32'hFFFF_FFFE, 0,     0, 32'hFC,  1, 0, 0);
        step("jmp_wins", 1, C_JUMP | C_PCSRC, 32'd5,        26'h40, 0, 32'h100, 1, 0, 0);

        step("jmp200",  1, C_JUMP,          0, 26'h80,  0, 32'h200, 1, 0, 0);
        step("jal",     1, C_JUMP | C_LINK, 0, 26'h100, 0, 32'h400, 0, 0, 0);
        step("seq404",  1, C_NONE,          0, 0,       0, 32'h404, 0, 0, 0);
        step("ret204",  1, C_JR | C_RET,    0, 0, 32'h999C, 32'h204, 1, 0, 0);
        step("jr3000",  1, C_JR,            0, 0, 32'h3000, 32'h3000, 1, 0, 0);
        step("ret_emp", 1, C_JR | C_RET,    0, 0, 32'h40,   32'h40,   1, 0, 0);

        step("jrC",   1, C_JR,          0, 0, 32'hC,    32'hC,    1, 0, 0);
        step("push1", 1, C_JR | C_LINK, 0, 0, 32'h1C,   32'h1C,   0, 0, 0);
        step("push2", 1, C_JR | C_LINK, 0, 0, 32'h2C,   32'h2C,   0, 0, 0);
        step("push3", 1, C_JR | C_LINK, 0, 0, 32'h3C,   32'h3C,   0, 0, 0);
        step("push4", 1, C_JR | C_LINK, 0, 0, 32'h4C,   32'h4C,   0, 1, 0);
        step("push5", 1, C_JR | C_LINK, 0, 0, 32'h1000, 32'h1000, 0, 1, 0);
        step("pop50", 1, C_JR | C_RET,  0, 0, 32'h8888, 32'h50,   0, 0, 0);
        step("pop40", 1, C_JR | C_RET,  0, 0, 32'h8888, 32'h40,   0, 0, 0);
        step("pop30", 1, C_JR | C_RET,  0, 0, 32'h8888, 32'h30,   0, 0, 0);
        step("pop20", 1, C_JR | C_RET,  0, 0, 32'h8888, 32'h20,   1, 0, 0);
        step("lost10",1, C_JR | C_RET,  0, 0, 32'h500,  32'h500,  1, 0, 0);

        step("push504", 1, C_JR | C_LINK,         0, 0, 32'h600,  32'h600, 0, 0, 0);
        step("poppush", 1, C_JR | C_RET | C_LINK, 0, 0, 32'h7777, 32'h504, 0, 0, 0);
        step("pop604",  1, C_JR | C_RET,          0, 0, 32'h7777, 32'h604, 1, 0, 0);
        step("lnk_ign", 1, C_LINK | C_RET,        0, 0, 32'h7777, 32'h608, 1, 0, 0);

        step("misal",    1, C_JR,            0, 0, 32'h1002, 32'h180, 1, 0, 1);
        step("mis_end",  1, C_NONE,          0, 0, 0,        32'h184, 1, 0, 0);
        step("stl_trap", 1, C_STALL | C_TRAP,0, 0, 0,        32'h180, 1, 0, 0);

        step("jr_top", 1, C_JR | C_LINK, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("stall", 1, C_STALL | C_JR | C_RET | C_LINK | C_PCSRC | C_JUMP,
                 32'd7, 26'h55, 32'h2000, 32'hFFFF_FFFC, 0, 0, 0);
        step("wrap0",  1, C_NONE,       0, 0, 0,        32'h0,   0, 0, 0);
        step("ret184", 1, C_JR | C_RET, 0, 0, 32'h2000, 32'h184, 1, 0, 0);

        step("misal2", 1, C_JR,    0,     0, 32'h1002, 32'h180, 1, 0, 1);
        step("rst_mid",0, C_PCSRC, 32'd3, 0, 0,        32'h0,   1, 0, 0);
        step("rst_rel",1, C_NONE,  0,     0, 0,        32'h4,   1, 0, 0);
        step("trap_jr",1, C_TRAP | C_JR, 0, 0, 32'h1002, 32'h180, 1, 0, 0);

        @(negedge clk);
        {stall, trap, pcsrc, jump, link, jr, ret} = C_NONE;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
